// File: rtl/dot_acc_pkg.sv
// rtl/dot_acc_pkg.sv - default widths, multiplier latency and FSM state type for the dot-product accumulator.
package dot_acc_pkg;

    localparam int PROD_W       = 16;
    localparam int ACC_W        = 24;
    localparam int LEN_W        = 8;
    localparam int MULT_LATENCY = 5;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - fixed-depth shift register tracking issued operand flags alongside the multiplier pipeline.
module valid_delay_line #(
    parameter int DEPTH     = 5,
    parameter int WIDTH     = 2,
    parameter int VALID_BIT = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             occupied
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    // Any valid bit still in the pipe means a product is in flight.
    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied = occupied | stage[i][VALID_BIT];
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - accumulates multiplier products into a dot product; DOT_ACC_SATURATE_EN selects saturation.
module dot_product_accumulator #(
    parameter int PROD_W       = dot_acc_pkg::PROD_W,
    parameter int ACC_W        = dot_acc_pkg::ACC_W,
    parameter int LEN_W        = dot_acc_pkg::LEN_W,
    parameter int MULT_LATENCY = dot_acc_pkg::MULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_last,
    input  logic [PROD_W-1:0] prod,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [LEN_W-1:0]  res_count,
    output logic              res_ovf,
    output logic              overrun,
    output logic              busy
);

    import dot_acc_pkg::*;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;

    logic [1:0]       tap;
    logic             p_valid;
    logic             p_last;
    logic             in_flight;

    logic             accum;
    logic [ACC_W-1:0] acc_base;
    logic [LEN_W-1:0] cnt_base;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] cnt_next;
    logic             ovf_next;

    // op_last is masked here so a stray last flag never reaches the tap.
    valid_delay_line #(
        .DEPTH     (MULT_LATENCY),
        .WIDTH     (2),
        .VALID_BIT (1)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .din      ({op_valid, op_valid & op_last}),
        .dout     (tap),
        .occupied (in_flight)
    );

    assign p_valid = tap[1];
    assign p_last  = tap[0];

    always_comb begin
        accum    = (state == ACCUM);
        acc_base = accum ? acc : '0;
        cnt_base = accum ? cnt : '0;
        sum      = {1'b0, acc_base} + (ACC_W+1)'(prod);
        cnt_next = cnt_base + LEN_W'(1);
        ovf_next = (accum & ovf) | sum[ACC_W];
`ifdef DOT_ACC_SATURATE_EN
        // Once clamped, every later add carries again (or adds zero), so the clamp holds.
        acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (p_valid) begin
                acc <= acc_next;
                cnt <= cnt_next;
                ovf <= ovf_next;
                if (p_last) begin
                    state <= IDLE;
                    // A completion coinciding with a transfer reloads the register.
                    if (!res_valid || res_ready) begin
                        res_valid <= 1'b1;
                        res_data  <= acc_next;
                        res_count <= cnt_next;
                        res_ovf   <= ovf_next;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    state <= ACCUM;
                end
            end
        end
    end

    assign busy = (state == ACCUM) | in_flight;

endmodule
